exe_stage: RTL and testbench

- EX stage of the 5-stage MIPS pipeline.
- Consumes ds_to_es_bus from the ID stage and drives es_to_ms_bus.
- Issues the data SRAM request and returns es_fwd_blk_bus to ID so ID can forward results or stall on them.
- Owns the HI/LO registers, a single-cycle multiplier and an iterative 32-cycle divider, which makes this stage multi-cycle.

---
 rtl/exe_stage_pkg.sv | 70 +++++++
 rtl/exe_stage_if.sv | 29 ++
 rtl/alu.sv | 40 ++++
 rtl/div_iter.sv | 79 +++++++
 rtl/exe_stage.sv | 109 ++++++++++
 tb/tb_exe_stage.sv | 242 ++++++++++++++++++++++++
 6 files changed

// File: rtl/exe_stage_pkg.sv
// Shared widths, opcode bit positions and bus payload layouts for the EX stage.
package exe_stage_pkg;

    localparam int unsigned DATA_W            = 32;
    localparam int unsigned DS_TO_ES_BUS_WD   = 145;
    localparam int unsigned ES_TO_MS_BUS_WD   = 71;
    localparam int unsigned ES_FWD_BLK_BUS_WD = 39;
    localparam int unsigned ALU_OP_W          = 12;

    // md_op = {div, divu, mult, multu}
    localparam int unsigned MD_DIV   = 3;
    localparam int unsigned MD_DIVU  = 2;
    localparam int unsigned MD_MULT  = 1;
    localparam int unsigned MD_MULTU = 0;

    // hl_op = {mfhi, mflo, mthi, mtlo}
    localparam int unsigned HL_MFHI = 3;
    localparam int unsigned HL_MFLO = 2;
    localparam int unsigned HL_MTHI = 1;
    localparam int unsigned HL_MTLO = 0;

    // One-hot ALU operation bit positions
    localparam int unsigned ALU_ADD  = 0;
    localparam int unsigned ALU_SUB  = 1;
    localparam int unsigned ALU_SLT  = 2;
    localparam int unsigned ALU_SLTU = 3;
    localparam int unsigned ALU_AND  = 4;
    localparam int unsigned ALU_NOR  = 5;
    localparam int unsigned ALU_OR   = 6;
    localparam int unsigned ALU_XOR  = 7;
    localparam int unsigned ALU_SLL  = 8;
    localparam int unsigned ALU_SRL  = 9;
    localparam int unsigned ALU_SRA  = 10;
    localparam int unsigned ALU_LUI  = 11;

    typedef struct packed {
        logic [3:0]          md_op;
        logic [3:0]          hl_op;
        logic [ALU_OP_W-1:0] alu_op;
        logic                load_op;
        logic                src1_is_sa;
        logic                src1_is_pc;
        logic                src2_is_imm;
        logic                src2_is_uimm;
        logic                src2_is_8;
        logic                gr_we;
        logic                mem_we;
        logic [4:0]          dest;
        logic [15:0]         imm;
        logic [DATA_W-1:0]   rs_value;
        logic [DATA_W-1:0]   rt_value;
        logic [DATA_W-1:0]   pc;
    } ds_to_es_t;

    typedef struct packed {
        logic              res_from_mem;
        logic              gr_we;
        logic [4:0]        dest;
        logic [DATA_W-1:0] result;
        logic [DATA_W-1:0] pc;
    } es_to_ms_t;

    typedef struct packed {
        logic              fwd_valid;
        logic [4:0]        rf_dest;
        logic [DATA_W-1:0] rf_data;
        logic              blk_valid;
    } es_fwd_blk_t;

endpackage

// File: rtl/exe_stage_if.sv
// Pipeline handshake, inter-stage buses and data SRAM request seen by the EX stage.
interface exe_stage_if;
    import exe_stage_pkg::*;

    logic        ms_allowin;
    logic        es_allowin;
    logic        ds_to_es_valid;
    ds_to_es_t   ds_to_es_bus;
    logic        es_to_ms_valid;
    es_to_ms_t   es_to_ms_bus;
    es_fwd_blk_t es_fwd_blk_bus;
    logic        data_sram_en;
    logic [3:0]  data_sram_wen;
    logic [31:0] data_sram_addr;
    logic [31:0] data_sram_wdata;

    modport master (
        input  ms_allowin, ds_to_es_valid, ds_to_es_bus,
        output es_allowin, es_to_ms_valid, es_to_ms_bus, es_fwd_blk_bus,
               data_sram_en, data_sram_wen, data_sram_addr, data_sram_wdata
    );

    modport slave (
        output ms_allowin, ds_to_es_valid, ds_to_es_bus,
        input  es_allowin, es_to_ms_valid, es_to_ms_bus, es_fwd_blk_bus,
               data_sram_en, data_sram_wen, data_sram_addr, data_sram_wdata
    );

endinterface

// File: rtl/alu.sv
// 12-operation one-hot ALU shared by arithmetic, logic, shift and address generation.
module alu
    import exe_stage_pkg::*;
(
    input  logic [ALU_OP_W-1:0] alu_op,
    input  logic [31:0]         alu_src1,
    input  logic [31:0]         alu_src2,
    output logic [31:0]         alu_result
);

    logic [31:0] add_res;
    logic [31:0] sub_res;
    logic [31:0] sra_res;
    logic        slt_res;
    logic        sltu_res;

    assign add_res  = alu_src1 + alu_src2;
    assign sub_res  = alu_src1 - alu_src2;
    assign slt_res  = $signed(alu_src1) < $signed(alu_src2);
    assign sltu_res = alu_src1 < alu_src2;
    assign sra_res  = $signed(alu_src2) >>> alu_src1[4:0];

    // Shift amount comes from src1, shifted value from src2
    always_comb begin
        alu_result = '0;
        alu_result = ({32{alu_op[ALU_ADD]}}  & add_res)
                   | ({32{alu_op[ALU_SUB]}}  & sub_res)
                   | ({32{alu_op[ALU_SLT]}}  & {31'b0, slt_res})
                   | ({32{alu_op[ALU_SLTU]}} & {31'b0, sltu_res})
                   | ({32{alu_op[ALU_AND]}}  & (alu_src1 & alu_src2))
                   | ({32{alu_op[ALU_NOR]}}  & ~(alu_src1 | alu_src2))
                   | ({32{alu_op[ALU_OR]}}   & (alu_src1 | alu_src2))
                   | ({32{alu_op[ALU_XOR]}}  & (alu_src1 ^ alu_src2))
                   | ({32{alu_op[ALU_SLL]}}  & (alu_src2 << alu_src1[4:0]))
                   | ({32{alu_op[ALU_SRL]}}  & (alu_src2 >> alu_src1[4:0]))
                   | ({32{alu_op[ALU_SRA]}}  & sra_res)
                   | ({32{alu_op[ALU_LUI]}}  & {alu_src2[15:0], 16'b0});
    end

endmodule

// File: rtl/div_iter.sv
// Restoring divider: one quotient bit per cycle, first bit computed on the start edge.
module div_iter #(
    parameter int unsigned DW = 32
) (
    input  logic          clk,
    input  logic          resetn,
    input  logic          start,
    input  logic          is_signed,
    input  logic [DW-1:0] dividend,
    input  logic [DW-1:0] divisor,
    input  logic          ack,
    output logic          busy,
    output logic          done,
    output logic [DW-1:0] quotient,
    output logic [DW-1:0] remainder
);

    localparam int unsigned CW = $clog2(DW) + 1;

    logic [DW-1:0] rem_q, quo_q, dsr_q;
    logic [CW-1:0] cnt_q;
    logic          neg_quo_q, neg_rem_q;

    logic [DW-1:0] abs_dividend, abs_divisor;
    logic [DW-1:0] r_in, q_in, d_in, r_nx, q_nx;
    logic [DW:0]   shifted;
    logic          ge;
    logic          last;

    assign abs_dividend = (is_signed && dividend[DW-1]) ? (~dividend + DW'(1)) : dividend;
    assign abs_divisor  = (is_signed && divisor[DW-1])  ? (~divisor + DW'(1))  : divisor;

    // Step operands come straight from the ports on the start edge
    assign r_in    = start ? '0 : rem_q;
    assign q_in    = start ? abs_dividend : quo_q;
    assign d_in    = start ? abs_divisor : dsr_q;
    assign shifted = {r_in, q_in[DW-1]};
    assign ge      = shifted >= {1'b0, d_in};
    assign r_nx    = ge ? (shifted[DW-1:0] - d_in) : shifted[DW-1:0];
    assign q_nx    = {q_in[DW-2:0], ge};
    assign last    = busy && (cnt_q == CW'(DW - 1));

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            busy      <= 1'b0;
            done      <= 1'b0;
            cnt_q     <= '0;
            rem_q     <= '0;
            quo_q     <= '0;
            dsr_q     <= '0;
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
            quotient  <= '0;
            remainder <= '0;
        end else if (start) begin
            busy      <= 1'b1;
            done      <= 1'b0;
            cnt_q     <= CW'(1);
            rem_q     <= r_nx;
            quo_q     <= q_nx;
            dsr_q     <= d_in;
            neg_quo_q <= is_signed && (dividend[DW-1] ^ divisor[DW-1]);
            neg_rem_q <= is_signed && dividend[DW-1];
        end else if (busy) begin
            rem_q <= r_nx;
            quo_q <= q_nx;
            cnt_q <= cnt_q + CW'(1);
            if (last) begin
                busy      <= 1'b0;
                done      <= 1'b1;
                quotient  <= neg_quo_q ? (~q_nx + DW'(1)) : q_nx;
                remainder <= neg_rem_q ? (~r_nx + DW'(1)) : r_nx;
            end
        end else if (ack) begin
            done <= 1'b0;
        end
    end

endmodule

// File: rtl/exe_stage.sv
// MIPS EX stage: ALU, HI/LO with multiply/divide, data SRAM request and forward/stall info for ID.
module exe_stage
    import exe_stage_pkg::*;
(
    input  logic        clk,
    input  logic        resetn,
    exe_stage_if.master io
);

    logic        es_valid;
    ds_to_es_t   es_q;
    logic [31:0] hi_q, lo_q;

    logic        is_div, is_mul, es_ready_go, handshake, rf_we;
    logic        div_start, div_busy, div_done;
    logic [31:0] quotient, remainder;
    logic [31:0] src1, src2, alu_result, es_result;
    logic [63:0] mul_a, mul_b, product;

    assign is_div      = es_q.md_op[MD_DIV] | es_q.md_op[MD_DIVU];
    assign is_mul      = es_q.md_op[MD_MULT] | es_q.md_op[MD_MULTU];
    assign es_ready_go = !is_div || div_done;
    assign io.es_allowin     = !es_valid || (es_ready_go && io.ms_allowin);
    assign io.es_to_ms_valid = es_valid && es_ready_go;
    assign handshake   = io.es_to_ms_valid && io.ms_allowin;
    assign div_start   = es_valid && is_div && !div_busy && !div_done;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            es_valid <= 1'b0;
            es_q     <= '0;
        end else begin
            if (io.es_allowin)
                es_valid <= io.ds_to_es_valid;
            if (io.ds_to_es_valid && io.es_allowin)
                es_q <= io.ds_to_es_bus;
        end
    end

    assign src1 = es_q.src1_is_sa   ? {27'b0, es_q.imm[10:6]} :
                  es_q.src1_is_pc   ? es_q.pc : es_q.rs_value;
    assign src2 = es_q.src2_is_imm  ? {{16{es_q.imm[15]}}, es_q.imm} :
                  es_q.src2_is_uimm ? {16'b0, es_q.imm} :
                  es_q.src2_is_8    ? 32'd8 : es_q.rt_value;

    alu u_alu (
        .alu_op    (es_q.alu_op),
        .alu_src1  (src1),
        .alu_src2  (src2),
        .alu_result(alu_result)
    );

    // Low 64 bits of the sign/zero-extended product are correct for both signednesses
    assign mul_a   = {{32{es_q.md_op[MD_MULT] & es_q.rs_value[31]}}, es_q.rs_value};
    assign mul_b   = {{32{es_q.md_op[MD_MULT] & es_q.rt_value[31]}}, es_q.rt_value};
    assign product = mul_a * mul_b;

    div_iter #(.DW(32)) u_div (
        .clk      (clk),
        .resetn   (resetn),
        .start    (div_start),
        .is_signed(es_q.md_op[MD_DIV]),
        .dividend (es_q.rs_value),
        .divisor  (es_q.rt_value),
        .ack      (handshake),
        .busy     (div_busy),
        .done     (div_done),
        .quotient (quotient),
        .remainder(remainder)
    );

    // HI/LO commit only when the instruction leaves EX
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            hi_q <= '0;
            lo_q <= '0;
        end else if (handshake) begin
            if (is_mul) begin
                hi_q <= product[63:32];
                lo_q <= product[31:0];
            end else if (is_div) begin
                hi_q <= remainder;
                lo_q <= quotient;
            end else begin
                if (es_q.hl_op[HL_MTHI]) hi_q <= es_q.rs_value;
                if (es_q.hl_op[HL_MTLO]) lo_q <= es_q.rs_value;
            end
        end
    end

    assign es_result = es_q.hl_op[HL_MFHI] ? hi_q :
                       es_q.hl_op[HL_MFLO] ? lo_q : alu_result;

    assign io.es_to_ms_bus = '{res_from_mem: es_q.load_op, gr_we: es_q.gr_we,
                               dest: es_q.dest, result: es_result, pc: es_q.pc};

    assign rf_we = es_valid && es_q.gr_we && (es_q.dest != 5'd0);
    assign io.es_fwd_blk_bus = '{fwd_valid: rf_we && !es_q.load_op && es_ready_go,
                                 rf_dest:   es_q.dest,
                                 rf_data:   es_result,
                                 blk_valid: rf_we && (es_q.load_op || !es_ready_go)};

    assign io.data_sram_en    = es_valid && es_ready_go && io.ms_allowin &&
                                (es_q.load_op | es_q.mem_we);
    assign io.data_sram_wen   = {4{es_q.mem_we && es_valid}};
    assign io.data_sram_addr  = alu_result;
    assign io.data_sram_wdata = es_q.rt_value;

endmodule

// File: tb/tb_exe_stage.sv
// Directed bench for exe_stage: single-cycle vector table plus divide, backpressure and reset sequences.
module tb_exe_stage;
    import exe_stage_pkg::*;

    logic clk = 1'b0;
    logic resetn;
    always #5 clk = ~clk;

    exe_stage_if io();

    exe_stage dut (
        .clk   (clk),
        .resetn(resetn),
        .io    (io)
    );

    localparam logic [3:0]  T_DIV = 4'b1000, T_DIVU = 4'b0100, T_MULT = 4'b0010, T_MULTU = 4'b0001;
    localparam logic [3:0]  T_MFHI = 4'b1000, T_MFLO = 4'b0100, T_MTHI = 4'b0010, T_MTLO = 4'b0001;
    localparam logic [11:0] O_ADD = 12'h001, O_SUB = 12'h002, O_SLT = 12'h004, O_SLTU = 12'h008;
    localparam logic [11:0] O_AND = 12'h010, O_NOR = 12'h020, O_OR = 12'h040, O_XOR = 12'h080;
    localparam logic [11:0] O_SLL = 12'h100, O_SRL = 12'h200, O_SRA = 12'h400, O_LUI = 12'h800;
    // flags = {load_op, src1_is_sa, src1_is_pc, src2_is_imm, src2_is_uimm, src2_is_8}
    localparam logic [5:0]  F_NONE = 6'b000000, F_LOAD = 6'b100000, F_SA = 6'b010000;
    localparam logic [5:0]  F_PC8 = 6'b001001, F_IMM = 6'b000100, F_UIMM = 6'b000010;

    typedef struct packed {
        logic [3:0]  md;
        logic [3:0]  hl;
        logic [11:0] alu;
        logic [5:0]  flags;
        logic [1:0]  we;      // {gr_we, mem_we}
        logic [4:0]  dest;
        logic [15:0] imm;
        logic [31:0] rs;
        logic [31:0] rt;
        logic [31:0] pc;
        logic [31:0] exp_res;
        logic        exp_fwd;
        logic        exp_blk;
        logic        exp_en;
        logic [3:0]  exp_wen;
        logic [31:0] exp_addr;
    } vec_t;

    vec_t vq[$];
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    function automatic void add(input vec_t v);
        vq.push_back(v);
    endfunction

    function automatic ds_to_es_t to_bus(input vec_t v);
        ds_to_es_t b;
        b = '0;
        b.md_op = v.md;
        b.hl_op = v.hl;
        b.alu_op = v.alu;
        {b.load_op, b.src1_is_sa, b.src1_is_pc, b.src2_is_imm, b.src2_is_uimm, b.src2_is_8} = v.flags;
        {b.gr_we, b.mem_we} = v.we;
        b.dest = v.dest;
        b.imm = v.imm;
        b.rs_value = v.rs;
        b.rt_value = v.rt;
        b.pc = v.pc;
        return b;
    endfunction

    function automatic ds_to_es_t mk(input logic [3:0] md, input logic [3:0] hl, input logic gr_we,
                                     input logic [4:0] dest, input logic [31:0] rs, input logic [31:0] rt);
        ds_to_es_t b;
        b = '0;
        b.md_op = md;
        b.hl_op = hl;
        b.gr_we = gr_we;
        b.dest = dest;
        b.rs_value = rs;
        b.rt_value = rt;
        b.pc = 32'h0040_1000;
        return b;
    endfunction

    // Offer one instruction; returns #1 after the edge that loads it into EX
    task automatic present(input ds_to_es_t b);
        int w;
        io.ds_to_es_bus = b;
        io.ds_to_es_valid = 1'b1;
        w = 0;
        while (!io.es_allowin && w < 100) begin
            @(posedge clk); #1;
            w++;
        end
        if (w >= 100) chk("allowin_timeout", 32'(io.es_allowin), 32'd1);
        @(posedge clk); #1;
        io.ds_to_es_valid = 1'b0;
    endtask

    task automatic read_hilo(input string tag, input logic [31:0] exp_hi, input logic [31:0] exp_lo);
        present(mk(4'h0, T_MFHI, 1'b1, 5'd2, 32'h0, 32'h0));
        chk({tag, "_hi"}, io.es_to_ms_bus.result, exp_hi);
        present(mk(4'h0, T_MFLO, 1'b1, 5'd2, 32'h0, 32'h0));
        chk({tag, "_lo"}, io.es_to_ms_bus.result, exp_lo);
    endtask

    task automatic run_div(input string tag, input logic [3:0] md, input logic [31:0] a,
                           input logic [31:0] b, input logic [31:0] exp_hi, input logic [31:0] exp_lo);
        int  n;
        bit  stall_ok;
        present(mk(md, 4'h0, 1'b1, 5'd5, a, b));
        n = 1;
        stall_ok = 1'b1;
        while (!io.es_to_ms_valid && n < 100) begin
            if (!io.es_fwd_blk_bus.blk_valid || io.es_fwd_blk_bus.fwd_valid || io.es_allowin)
                stall_ok = 1'b0;
            @(posedge clk); #1;
            n++;
        end
        chk({tag, "_residency"}, 32'(n), 32'd33);
        chk({tag, "_stall_flags"}, 32'(stall_ok), 32'd1);
        chk({tag, "_done_fwd"}, {30'b0, io.es_fwd_blk_bus.fwd_valid, io.es_fwd_blk_bus.blk_valid}, 32'd2);
        read_hilo(tag, exp_hi, exp_lo);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, checks %0d", checks);
        $fatal(1);
    end

    initial begin
        int  n;
        bit  hold_ok;
        vec_t v;

        resetn = 1'b0;
        io.ms_allowin = 1'b1;
        io.ds_to_es_valid = 1'b0;
        io.ds_to_es_bus = '0;

        //   md      hl      alu     flags   we     dest   imm       rs            rt            pc             exp_res       fwd   blk   en    wen   addr
        add('{4'h0,  T_MFHI, 12'h0,  F_NONE, 2'b10, 5'd2,  16'h0000, 32'h0,        32'h0,        32'h0040_0000, 32'h0,        1'b1, 1'b0, 1'b0, 4'h0, 32'h0});
        add('{4'h0,  T_MFLO, 12'h0,  F_NONE, 2'b10, 5'd2,  16'h0000, 32'h0,        32'h0,        32'h0040_0004, 32'h0,        1'b1, 1'b0, 1'b0, 4'h0, 32'h0});
        add('{4'h0,  4'h0,   O_ADD,  F_NONE, 2'b10, 5'd3,  16'h0000, 32'd5,        32'd7,        32'h0040_0008, 32'd12,       1'b1, 1'b0, 1'b0, 4'h0, 32'h0});
        add('{4'h0,  4'h0,   O_ADD,  F_LOAD | F_IMM, 2'b10, 5'd4, 16'h0010, 32'h1000, 32'h0,     32'h0040_000C, 32'h1010,     1'b0, 1'b1, 1'b1, 4'h0, 32'h1010});
        add('{4'h0,  4'h0,   O_ADD,  F_IMM,  2'b01, 5'd0,  16'hFFFC, 32'h2000,     32'hDEADBEEF, 32'h0040_0010, 32'h1FFC,     1'b0, 1'b0, 1'b1, 4'hF, 32'h1FFC});
        add('{4'h0,  4'h0,   O_SUB,  F_NONE, 2'b10, 5'd5,  16'h0000, 32'd3,        32'd5,        32'h0040_0014, 32'hFFFFFFFE, 1'b1, 1'b0, 1'b0, 4'h0, 32'h0});
        add('{4'h0,  4'h0,   O_SLT,  F_NONE, 2'b10, 5'd6,  16'h0000, 32'hFFFFFFFF, 32'd1,        32'h0040_0018, 32'd1,        1'b1, 1'b0, 1'b0, 4'h0, 32'h0});
        add('{4'h0,  4'h0,   O_SLTU, F_NONE, 2'b10, 5'd6,  16'h0000, 32'hFFFFFFFF, 32'd1,        32'h0040_001C, 32'd0,        1'b1, 1'b0, 1'b0, 4'h0, 32'h0});
        add('{4'h0,  4'h0,   O_OR,   F_UIMM, 2'b10, 5'd7,  16'h8001, 32'h0001_0000, 32'h0,       32'h0040_0020, 32'h0001_8001, 1'b1, 1'b0, 1'b0, 4'h0, 32'h0});
        add('{4'h0,  4'h0,   O_SLL,  F_SA,   2'b10, 5'd8,  16'h0100, 32'hFFFF_FFFF, 32'd3,       32'h0040_0024, 32'h30,       1'b1, 1'b0, 1'b0, 4'h0, 32'h0});
        add('{4'h0,  4'h0,   O_SRA,  F_SA,   2'b10, 5'd9,  16'h0100, 32'h0,        32'h8000_0000, 32'h0040_0028, 32'hF800_0000, 1'b1, 1'b0, 1'b0, 4'h0, 32'h0});
        add('{4'h0,  4'h0,   O_SRL,  F_SA,   2'b10, 5'd9,  16'h0100, 32'h0,        32'h8000_0000, 32'h0040_002C, 32'h0800_0000, 1'b1, 1'b0, 1'b0, 4'h0, 32'h0});
        add('{4'h0,  4'h0,   O_LUI,  F_IMM,  2'b10, 5'd10, 16'h1234, 32'h0,        32'h0,        32'h0040_0030, 32'h1234_0000, 1'b1, 1'b0, 1'b0, 4'h0, 32'h0});
        add('{4'h0,  4'h0,   O_ADD,  F_PC8,  2'b10, 5'd31, 16'h0000, 32'h1111,     32'h2222,     32'hBFC0_0100, 32'hBFC0_0108, 1'b1, 1'b0, 1'b0, 4'h0, 32'h0});
        add('{4'h0,  4'h0,   O_NOR,  F_NONE, 2'b10, 5'd11, 16'h0000, 32'h0F0F_0F0F, 32'h00FF_00FF, 32'h0040_0034, 32'hF000_F000, 1'b1, 1'b0, 1'b0, 4'h0, 32'h0});
        add('{4'h0,  4'h0,   O_AND,  F_NONE, 2'b10, 5'd11, 16'h0000, 32'h0F0F_0F0F, 32'h00FF_00FF, 32'h0040_0038, 32'h000F_000F, 1'b1, 1'b0, 1'b0, 4'h0, 32'h0});
        add('{4'h0,  4'h0,   O_XOR,  F_NONE, 2'b10, 5'd11, 16'h0000, 32'h0F0F_0F0F, 32'h00FF_00FF, 32'h0040_003C, 32'h0FF0_0FF0, 1'b1, 1'b0, 1'b0, 4'h0, 32'h0});
        add('{4'h0,  4'h0,   O_ADD,  F_NONE, 2'b10, 5'd0,  16'h0000, 32'd5,        32'd7,        32'h0040_0040, 32'd12,       1'b0, 1'b0, 1'b0, 4'h0, 32'h0});
        add('{T_MULTU, 4'h0, 12'h0,  F_NONE, 2'b00, 5'd0,  16'h0000, 32'hFFFFFFFF, 32'd2,        32'h0040_0044, 32'h0,        1'b0, 1'b0, 1'b0, 4'h0, 32'h0});
        add('{4'h0,  T_MFHI, 12'h0,  F_NONE, 2'b10, 5'd12, 16'h0000, 32'h0,        32'h0,        32'h0040_0048, 32'd1,        1'b1, 1'b0, 1'b0, 4'h0, 32'h0});
        add('{4'h0,  T_MFLO, 12'h0,  F_NONE, 2'b10, 5'd12, 16'h0000, 32'h0,        32'h0,        32'h0040_004C, 32'hFFFFFFFE, 1'b1, 1'b0, 1'b0, 4'h0, 32'h0});
        add('{T_MULT, 4'h0,  12'h0,  F_NONE, 2'b00, 5'd0,  16'h0000, 32'hFFFFFFFD, 32'd5,        32'h0040_0050, 32'h0,        1'b0, 1'b0, 1'b0, 4'h0, 32'h0});
        add('{4'h0,  T_MFHI, 12'h0,  F_NONE, 2'b10, 5'd13, 16'h0000, 32'h0,        32'h0,        32'h0040_0054, 32'hFFFFFFFF, 1'b1, 1'b0, 1'b0, 4'h0, 32'h0});
        add('{4'h0,  T_MFLO, 12'h0,  F_NONE, 2'b10, 5'd13, 16'h0000, 32'h0,        32'h0,        32'h0040_0058, 32'hFFFFFFF1, 1'b1, 1'b0, 1'b0, 4'h0, 32'h0});
        add('{4'h0,  T_MTHI, 12'h0,  F_NONE, 2'b00, 5'd0,  16'h0000, 32'h55,       32'h0,        32'h0040_005C, 32'h0,        1'b0, 1'b0, 1'b0, 4'h0, 32'h0});
        add('{4'h0,  T_MTLO, 12'h0,  F_NONE, 2'b00, 5'd0,  16'h0000, 32'hAA,       32'h0,        32'h0040_0060, 32'h0,        1'b0, 1'b0, 1'b0, 4'h0, 32'h0});
        add('{4'h0,  T_MFHI, 12'h0,  F_NONE, 2'b10, 5'd14, 16'h0000, 32'h0,        32'h0,        32'h0040_0064, 32'h55,       1'b1, 1'b0, 1'b0, 4'h0, 32'h0});
        add('{4'h0,  T_MFLO, 12'h0,  F_NONE, 2'b10, 5'd14, 16'h0000, 32'h0,        32'h0,        32'h0040_0068, 32'hAA,       1'b1, 1'b0, 1'b0, 4'h0, 32'h0});

        // Reset-state outputs
        #12;
        chk("rst_allowin", 32'(io.es_allowin), 32'd1);
        chk("rst_to_ms_valid", 32'(io.es_to_ms_valid), 32'd0);
        chk("rst_sram_en", 32'(io.data_sram_en), 32'd0);
        chk("rst_fwd_blk", {30'b0, io.es_fwd_blk_bus.fwd_valid, io.es_fwd_blk_bus.blk_valid}, 32'd0);
        @(negedge clk);
        resetn = 1'b1;

        for (int i = 0; i < vq.size(); i++) begin
            v = vq[i];
            present(to_bus(v));
            chk($sformatf("vec%0d_result", i), io.es_to_ms_bus.result, v.exp_res);
            chk($sformatf("vec%0d_pc", i), io.es_to_ms_bus.pc, v.pc);
            chk($sformatf("vec%0d_to_ms_valid", i), 32'(io.es_to_ms_valid), 32'd1);
            chk($sformatf("vec%0d_fwd", i), 32'(io.es_fwd_blk_bus.fwd_valid), 32'(v.exp_fwd));
            chk($sformatf("vec%0d_blk", i), 32'(io.es_fwd_blk_bus.blk_valid), 32'(v.exp_blk));
            chk($sformatf("vec%0d_rf_dest", i), 32'(io.es_fwd_blk_bus.rf_dest), 32'(v.dest));
            chk($sformatf("vec%0d_rf_data", i), io.es_fwd_blk_bus.rf_data, v.exp_res);
            chk($sformatf("vec%0d_sram_en", i), 32'(io.data_sram_en), 32'(v.exp_en));
            chk($sformatf("vec%0d_sram_wen", i), 32'(io.data_sram_wen), 32'(v.exp_wen));
            if (v.exp_en)
                chk($sformatf("vec%0d_sram_addr", i), io.data_sram_addr, v.exp_addr);
            if (v.exp_wen != 4'h0)
                chk($sformatf("vec%0d_sram_wdata", i), io.data_sram_wdata, v.rt);
        end

        run_div("div_100_7", T_DIV, 32'd100, 32'd7, 32'd2, 32'd14);
        run_div("div_m7_2", T_DIV, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD);
        run_div("divu_5_0", T_DIVU, 32'd5, 32'd0, 32'd5, 32'hFFFFFFFF);

        // MEM backpressure while the divide completes: result holds, no restart
        present(mk(T_DIVU, 4'h0, 1'b1, 5'd5, 32'd20, 32'd6));
        io.ms_allowin = 1'b0;
        hold_ok = 1'b1;
        for (int c = 1; c <= 45; c++) begin
            if (c >= 33 && !io.es_to_ms_valid) hold_ok = 1'b0;
            if (io.es_allowin || io.data_sram_en) hold_ok = 1'b0;
            @(posedge clk); #1;
        end
        chk("bp_hold", 32'(hold_ok), 32'd1);
        chk("bp_valid_end", 32'(io.es_to_ms_valid), 32'd1);
        io.ms_allowin = 1'b1;
        read_hilo("bp_divu_20_6", 32'd2, 32'd3);

        // Async reset in the middle of a divide
        present(mk(T_DIV, 4'h0, 1'b1, 5'd5, 32'd100, 32'd7));
        repeat (10) @(posedge clk);
        #2 resetn = 1'b0;
        #1;
        chk("mid_rst_to_ms_valid", 32'(io.es_to_ms_valid), 32'd0);
        chk("mid_rst_allowin", 32'(io.es_allowin), 32'd1);
        chk("mid_rst_blk", 32'(io.es_fwd_blk_bus.blk_valid), 32'd0);
        @(negedge clk);
        resetn = 1'b1;
        read_hilo("after_rst", 32'd0, 32'd0);
        run_div("div_9_3", T_DIV, 32'd9, 32'd3, 32'd0, 32'd3);

        n = checks;
        @(posedge clk); #1;
        $display("Simulation finished: %0d checks, %0d errors", n, errors);
        $finish;
    end

endmodule
